// File: rtl/fir_tdm_if.sv
// rtl/fir_tdm_if.sv - sample, coefficient and result signals of the time-shared FIR
interface fir_tdm_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int CH     = 2
) ();
    localparam int TAP_W = $clog2(TAPS);

    logic [CH*DATA_W-1:0] in;
    logic                 input_ready;
    logic                 coef_wr;
    logic [TAP_W-1:0]     coef_addr;
    logic [COEF_W-1:0]    coef_data;
    logic [CH*DATA_W-1:0] out;
    logic                 output_ready;
    logic                 busy;
    logic                 overrun;

    modport master (
        output in, input_ready, coef_wr, coef_addr, coef_data,
        input  out, output_ready, busy, overrun
    );

    modport slave (
        input  in, input_ready, coef_wr, coef_addr, coef_data,
        output out, output_ready, busy, overrun
    );
endinterface

// File: rtl/fir_tdm.sv
// rtl/fir_tdm.sv - multi-channel FIR sharing one multiplier across channels and taps
module fir_tdm #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int CH     = 2,
    parameter int SHIFT  = 15
) (
    input logic      ck,
    input logic      rst,
    fir_tdm_if.slave bus
);
    localparam int TAP_W  = $clog2(TAPS);
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);

    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] MAX_V =
        {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V =
        {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]               state;
    logic                     ready_q;
    logic                     armed;
    logic                     start;
    logic signed [DATA_W-1:0] x [CH][TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [TAP_W-1:0]         tap_cnt;
    logic [CH_W-1:0]          ch_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] stage [CH];

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  sum;

    // armed stays low after reset until input_ready is seen low, so a strobe
    // held across reset release cannot masquerade as a fresh rising edge
    assign start = bus.input_ready & ~ready_q & armed;

    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] r;
        r = $signed({a[ACC_W-1], a}) + RND;
        r = r >>> SHIFT;
        if (r > MAX_V)
            return MAX_V[DATA_W-1:0];
        else if (r < MIN_V)
            return MIN_V[DATA_W-1:0];
        else
            return r[DATA_W-1:0];
    endfunction

    always_comb begin
        prod = $signed({{COEF_W{x[ch_cnt][tap_cnt][DATA_W-1]}}, x[ch_cnt][tap_cnt]})
             * $signed({{DATA_W{coef[tap_cnt][COEF_W-1]}}, coef[tap_cnt]});
        acc_base = acc;
        if (tap_cnt == '0)
            acc_base = '0;
        sum = acc_base + ACC_W'(prod);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state            <= S_IDLE;
            ready_q          <= 1'b0;
            armed            <= 1'b0;
            tap_cnt          <= '0;
            ch_cnt           <= '0;
            acc              <= '0;
            bus.out          <= '0;
            bus.output_ready <= 1'b0;
            bus.busy         <= 1'b0;
            bus.overrun      <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                stage[c] <= '0;
                for (int k = 0; k < TAPS; k++)
                    x[c][k] <= '0;
            end
            for (int k = 0; k < TAPS; k++)
                coef[k] <= '0;
        end else begin
            ready_q          <= bus.input_ready;
            bus.output_ready <= 1'b0;
            bus.overrun      <= 1'b0;
            if (!bus.input_ready)
                armed <= 1'b1;

            if (bus.coef_wr && state == S_IDLE &&
                {1'b0, bus.coef_addr} < (TAP_W+1)'(TAPS))
                coef[bus.coef_addr] <= bus.coef_data;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < CH; c++) begin
                            x[c][0] <= bus.in[c*DATA_W +: DATA_W];
                            for (int k = 1; k < TAPS; k++)
                                x[c][k] <= x[c][k-1];
                        end
                        tap_cnt  <= '0;
                        ch_cnt   <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (start)
                        bus.overrun <= 1'b1;
                    acc <= sum;
                    if (tap_cnt == TAP_LAST) begin
                        stage[ch_cnt] <= round_sat(sum);
                        tap_cnt       <= '0;
                        if (ch_cnt == CH_LAST) begin
                            ch_cnt <= '0;
                            state  <= S_DONE;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                        end
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (start)
                        bus.overrun <= 1'b1;
                    for (int c = 0; c < CH; c++)
                        bus.out[c*DATA_W +: DATA_W] <= stage[c];
                    bus.output_ready <= 1'b1;
                    bus.busy         <= 1'b0;
                    state            <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule
